lmg_move_packer: RTL and testbench
==================================

// Module: lmg_move_packer
// PURPOSE
//  Transmit side of the LMG move-list FIFO interface. It collects single 18-bit moves
//  from the move-generation datapath, packs them 8 per 152-bit word, and buffers the
//  words in an internal FIFO. On generation-done it flushes and terminates the list,
//  then raises done for the control block, which drains it with rden / fifo_out.
// PARAMETERS
//  MOVE_W  18  width of one encoded move
//  SLOTS   8   moves per word; word width W = SLOTS*(MOVE_W+1) = 152
//  DEPTH   32  FIFO depth in words (power of 2)
//  ADDR_W  5   log2(DEPTH)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       asynchronous, active-high reset
//  clear       in   1       synchronous restart; same effect as reset, one cycle
//  move_valid  in   1       move_in is valid this cycle
//  move_in     in   MOVE_W  encoded move
//  move_ready  out  1       packer accepts move_in this cycle
//  gen_done    in   1       pulse: generator has issued its last move
//  rden        in   1       pop one word from the FIFO
//  fifo_out    out  W       registered FIFO read data
//  done        out  1       list is complete in the FIFO, terminator included
//  fifo_empty  out  1       FIFO holds no words
//  move_count  out  9       total moves accepted since reset/clear; saturates at 511
// BEHAVIOUR
//  Word format:
//   - Slot i occupies [19i+18:19i]. Bit 19i+18 is the INVALID flag (1 = empty slot).
//   - [19i+17:19i] holds the move. The first move of a word goes in slot 0.
//   - TERM word: every INVALID flag = 1, every move field = 0.
//  Reset/clear values:
//   - fifo_out = TERM, done = 0, move_ready = 1, fifo_empty = 1, move_count = 0.
//   - Slot counter = 0, FIFO pointers = 0, state = PACK.
//  Pack register and slot counter cnt (0..7):
//   - A move is accepted when move_valid && move_ready.
//   - When cnt < 7, the move goes into slot cnt and cnt increments.
//   - When cnt == 7, {move, pack[132:0]} is written into the FIFO on the same edge
//     and cnt returns to 0.
//   - move_ready = (state == PACK) && !(cnt == 7 && fifo_full).
//  FSM:
//   - PACK: accepts moves. gen_done moves to FLUSH. A move and gen_done in the same
//     cycle: the move is accepted first and is included in the flush.
//   - FLUSH: if cnt > 0 and the FIFO is not full, push the pack register with unused
//     slots INVALID=1 and move=0, clear cnt, go to TERM. If cnt == 0, go to TERM with
//     no push. While the FIFO is full, stay in FLUSH.
//   - TERM: when the FIFO is not full, push TERM and go to DONE.
//   - DONE: done = 1, held until reset or clear. move_valid and gen_done are ignored.
//  FIFO:
//   - Circular buffer with ADDR_W-bit pointers that wrap modulo DEPTH.
//   - An occupancy counter of ADDR_W+1 bits gives full/empty.
//   - Push and pop in the same cycle: both occur and occupancy is unchanged.
//   - Pop latency 1: rden at edge N loads fifo_out at edge N, so it is visible in cycle N+1.
//   - rden while empty: fifo_out <= TERM and pointers unchanged (no underflow).
//   - Without rden, fifo_out holds its value.
//   - Reads are legal in every state, including PACK before done.
//  move_count increments on each accepted move and saturates at 511.
//  clear asserted in any state aborts the list: the pending partial word is discarded.
//  Reset or clear asserted mid-operation returns all outputs to their reset values.
// TESTING
//  - 3 moves (A, B, C), then gen_done, then 2 rden: word0 slots 0-2 = A, B, C with
//    valid flags; slots 3-7 INVALID. word1 = TERM. done = 1 after the TERM push;
//    move_count = 3.
//  - Exactly 8 moves, then gen_done: the FIFO holds 2 words, the full word then TERM.
//    No empty padded word is produced.
//  - 8 moves with gen_done on the 8th move's cycle: same result as the previous
//    scenario; move_count = 8.
//  - 263 moves (32 words + 7) with no rden: move_ready = 0 while waiting for the 264th
//    move. One rden -> the stall clears; that word is accepted the next cycle.
//  - rden on an empty FIFO after reset: fifo_out = TERM, fifo_empty stays 1, pointers
//    unchanged.
//  - clear asserted in PACK with cnt = 5 and 2 words queued: next cycle fifo_empty = 1,
//    done = 0, move_count = 0, fifo_out = TERM.

Source files
------------

// File: rtl/lmg_move_packer.sv
// LMG move-list transmit packer: packs moves 8 per word into a word FIFO,
// then flushes and terminates the list on generation-done.
module lmg_move_packer #(
  parameter int MOVE_W = 18,
  parameter int SLOTS  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          move_valid,
  input  logic [MOVE_W-1:0]             move_in,
  output logic                          move_ready,
  input  logic                          gen_done,
  input  logic                          rden,
  output logic [SLOTS*(MOVE_W+1)-1:0]   fifo_out,
  output logic                          done,
  output logic                          fifo_empty,
  output logic [8:0]                    move_count
);

  localparam int SLOT_W = MOVE_W + 1;
  localparam int W      = SLOTS * SLOT_W;
  localparam int CNT_W  = $clog2(SLOTS);

  localparam logic [SLOT_W-1:0] EMPTY_SLOT = {1'b1, {MOVE_W{1'b0}}};
  localparam logic [W-1:0]      TERM_WORD  = {SLOTS{EMPTY_SLOT}};

  typedef enum logic [1:0] {
    ST_PACK,
    ST_FLUSH,
    ST_TERM,
    ST_DONE
  } state_t;

  state_t state, nextState;

  logic [W-1:0]      pack;
  logic [CNT_W-1:0]  cnt;
  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [ADDR_W:0]   occ;

  logic         fifoFull;
  logic         lastSlot;
  logic         accept;
  logic         push;
  logic         pop;
  logic [W-1:0] pushData;

  assign fifoFull   = occ == (ADDR_W+1)'(DEPTH);
  assign fifo_empty = occ == '0;
  assign lastSlot   = cnt == CNT_W'(SLOTS-1);
  assign move_ready = (state == ST_PACK) && !(lastSlot && fifoFull);
  assign accept     = move_valid && move_ready;
  assign pop        = rden && !fifo_empty;
  assign done       = state == ST_DONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      state <= ST_PACK;
    else if (clear) state <= ST_PACK;
    else            state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_PACK:  if (gen_done) nextState = ST_FLUSH;
      ST_FLUSH: if (cnt == '0 || !fifoFull) nextState = ST_TERM;
      ST_TERM:  if (!fifoFull) nextState = ST_DONE;
      default:  nextState = state;
    endcase
  end

  // The eighth move bypasses the pack register straight into the FIFO.
  always_comb begin
    push     = 1'b0;
    pushData = pack;
    unique case (state)
      ST_PACK: begin
        if (accept && lastSlot) begin
          push     = 1'b1;
          pushData = {1'b0, move_in, pack[W-SLOT_W-1:0]};
        end
      end
      ST_FLUSH: push = (cnt != '0) && !fifoFull;
      ST_TERM: begin
        push     = !fifoFull;
        pushData = TERM_WORD;
      end
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      pack <= TERM_WORD;
    end else if (clear) begin
      cnt  <= '0;
      pack <= TERM_WORD;
    end else if (accept) begin
      if (lastSlot) begin
        cnt  <= '0;
        pack <= TERM_WORD;
      end else begin
        pack[int'(cnt)*SLOT_W +: SLOT_W] <= {1'b0, move_in};
        cnt <= cnt + 1'b1;
      end
    end else if (state == ST_FLUSH && push) begin
      cnt  <= '0;
      pack <= TERM_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      occ      <= '0;
      fifo_out <= TERM_WORD;
    end else if (clear) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      occ      <= '0;
      fifo_out <= TERM_WORD;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (rden) fifo_out <= fifo_empty ? TERM_WORD : mem[rdPtr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      move_count <= '0;
    else if (clear)
      move_count <= '0;
    else if (accept && move_count != 9'h1FF)
      move_count <= move_count + 1'b1;
  end

endmodule

// File: tb/tb_lmg_move_packer.sv
// Randomized bench for lmg_move_packer against a list-level
// model of move packing, flush, termination and FIFO drain.
module tb_lmg_move_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         move_valid;
  logic [17:0]  move_in;
  logic         move_ready;
  logic         gen_done;
  logic         rden;
  logic [151:0] fifo_out;
  logic         done;
  logic         fifo_empty;
  logic [8:0]   move_count;

  int nVec = 0;
  int nMis = 0;

  int           mPhase;
  int           mCount;
  logic [17:0]  mPart[$];
  logic [151:0] mFifo[$];
  logic [151:0] mOut;
  logic [151:0] termW;

  lmg_move_packer dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .move_valid(move_valid),
    .move_in(move_in),
    .move_ready(move_ready),
    .gen_done(gen_done),
    .rden(rden),
    .fifo_out(fifo_out),
    .done(done),
    .fifo_empty(fifo_empty),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  function automatic logic [151:0] buildWord(input logic [17:0] mv[$]);
    logic [151:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < mv.size()) w[i*19 +: 19] = {1'b0, mv[i]};
      else               w[i*19 +: 19] = {1'b1, 18'd0};
    end
    return w;
  endfunction

  function automatic bit mReady();
    return mPhase == 0 && !(mPart.size() == 7 && mFifo.size() == 32);
  endfunction

  function automatic void modelReset();
    mPhase = 0;
    mCount = 0;
    mPart.delete();
    mFifo.delete();
    mOut = termW;
  endfunction

  function automatic void modelEdge(input bit mv, input logic [17:0] m,
                                    input bit gd, input bit rd);
    bit ready, full, wasEmpty, doPush;
    logic [151:0] pw;
    ready    = mReady();
    full     = mFifo.size() == 32;
    wasEmpty = mFifo.size() == 0;
    doPush   = 0;
    pw       = termW;
    case (mPhase)
      0: begin
        if (mv && ready) begin
          if (mCount < 511) mCount++;
          mPart.push_back(m);
          if (mPart.size() == 8) begin
            pw = buildWord(mPart);
            doPush = 1;
            mPart.delete();
          end
        end
        if (gd) mPhase = 1;
      end
      1: begin
        if (mPart.size() == 0) mPhase = 2;
        else if (!full) begin
          pw = buildWord(mPart);
          doPush = 1;
          mPart.delete();
          mPhase = 2;
        end
      end
      2: if (!full) begin
        doPush = 1;
        mPhase = 3;
      end
      default: ;
    endcase
    if (rd) mOut = wasEmpty ? termW : mFifo.pop_front();
    if (doPush) mFifo.push_back(pw);
  endfunction

  task automatic step(input bit mv, input logic [17:0] m,
                      input bit gd, input bit rd);
    move_valid = mv;
    move_in    = m;
    gen_done   = gd;
    rden       = rd;
    @(posedge clk);
    modelEdge(mv, m, gd, rd);
    @(negedge clk);
    move_valid = 0;
    gen_done   = 0;
    rden       = 0;
  endtask

  task automatic doClear();
    clear = 1;
    @(posedge clk);
    modelReset();
    @(negedge clk);
    clear = 0;
  endtask

  task automatic runToDone();
    for (int i = 0; i < 12 && !done; i++) step(0, '0, 0, 0);
  endtask

  task automatic test_reset();
    nVec++;
    if (fifo_out !== termW) begin
      nMis++; $display("FAIL rst_out got %h want %h", fifo_out, termW);
    end
    nVec++;
    if (done !== 1'b0) begin
      nMis++; $display("FAIL rst_done got %b want 0", done);
    end
    nVec++;
    if (move_ready !== 1'b1) begin
      nMis++; $display("FAIL rst_ready got %b want 1", move_ready);
    end
    nVec++;
    if (fifo_empty !== 1'b1) begin
      nMis++; $display("FAIL rst_empty got %b want 1", fifo_empty);
    end
    nVec++;
    if (move_count !== 9'd0) begin
      nMis++; $display("FAIL rst_count got %0d want 0", move_count);
    end
  endtask

  task automatic test_empty_read();
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    nVec++;
    if (fifo_out !== termW) begin
      nMis++; $display("FAIL empty_rd_out got %h want %h", fifo_out, termW);
    end
    nVec++;
    if (fifo_empty !== 1'b1) begin
      nMis++; $display("FAIL empty_rd_empty got %b want 1", fifo_empty);
    end
  endtask

  task automatic test_three_moves();
    logic [17:0] q[$];
    logic [151:0] exp0;
    for (int i = 0; i < 3; i++) q.push_back(18'($urandom));
    exp0 = buildWord(q);
    for (int i = 0; i < 3; i++) step(1, q[i], 0, 0);
    step(0, '0, 1, 0);
    runToDone();
    nVec++;
    if (done !== 1'b1) begin
      nMis++; $display("FAIL three_done got %b want 1", done);
    end
    nVec++;
    if (move_count !== 9'd3) begin
      nMis++; $display("FAIL three_count got %0d want 3", move_count);
    end
    step(0, '0, 0, 1);
    nVec++;
    if (fifo_out !== exp0) begin
      nMis++; $display("FAIL three_word0 got %h want %h", fifo_out, exp0);
    end
    step(0, '0, 0, 1);
    nVec++;
    if (fifo_out !== termW) begin
      nMis++; $display("FAIL three_term got %h want %h", fifo_out, termW);
    end
    nVec++;
    if (fifo_empty !== 1'b1) begin
      nMis++; $display("FAIL three_empty got %b want 1", fifo_empty);
    end
  endtask

  task automatic test_eight(input bit sameCycle);
    logic [17:0] q[$];
    logic [151:0] exp0;
    doClear();
    for (int i = 0; i < 8; i++) q.push_back(18'($urandom));
    exp0 = buildWord(q);
    for (int i = 0; i < 8; i++) step(1, q[i], sameCycle && i == 7, 0);
    if (!sameCycle) step(0, '0, 1, 0);
    runToDone();
    nVec++;
    if (done !== 1'b1) begin
      nMis++; $display("FAIL eight%0d_done got %b want 1", sameCycle, done);
    end
    nVec++;
    if (move_count !== 9'd8) begin
      nMis++; $display("FAIL eight%0d_count got %0d want 8", sameCycle, move_count);
    end
    step(0, '0, 0, 1);
    nVec++;
    if (fifo_out !== exp0) begin
      nMis++; $display("FAIL eight%0d_word got %h want %h", sameCycle, fifo_out, exp0);
    end
    step(0, '0, 0, 1);
    nVec++;
    if (fifo_out !== termW) begin
      nMis++; $display("FAIL eight%0d_term got %h want %h", sameCycle, fifo_out, termW);
    end
    nVec++;
    if (fifo_empty !== 1'b1) begin
      nMis++; $display("FAIL eight%0d_nopad got %b want 1", sameCycle, fifo_empty);
    end
  endtask

  task automatic test_stall();
    logic [17:0] m264;
    doClear();
    for (int i = 0; i < 263; i++) step(1, 18'($urandom), 0, 0);
    m264 = 18'($urandom);
    nVec++;
    if (move_ready !== 1'b0) begin
      nMis++; $display("FAIL stall_ready got %b want 0", move_ready);
    end
    step(1, m264, 0, 0);
    nVec++;
    if (move_count !== 9'd263) begin
      nMis++; $display("FAIL stall_count got %0d want 263", move_count);
    end
    nVec++;
    if (move_ready !== 1'b0) begin
      nMis++; $display("FAIL stall_hold got %b want 0", move_ready);
    end
    step(1, m264, 0, 1);
    nVec++;
    if (move_ready !== 1'b1) begin
      nMis++; $display("FAIL stall_release got %b want 1", move_ready);
    end
    nVec++;
    if (fifo_out !== mOut) begin
      nMis++; $display("FAIL stall_pop got %h want %h", fifo_out, mOut);
    end
    step(1, m264, 0, 0);
    nVec++;
    if (move_count !== 9'd264) begin
      nMis++; $display("FAIL stall_accept got %0d want 264", move_count);
    end
    nVec++;
    if (move_ready !== mReady()) begin
      nMis++; $display("FAIL stall_full got %b want %b", move_ready, mReady());
    end
  endtask

  task automatic test_clear_mid();
    doClear();
    for (int i = 0; i < 29; i++) step(1, 18'($urandom), 0, 0);
    step(0, '0, 0, 1);
    nVec++;
    if (fifo_out !== mOut) begin
      nMis++; $display("FAIL clr_pre got %h want %h", fifo_out, mOut);
    end
    doClear();
    nVec++;
    if (fifo_empty !== 1'b1) begin
      nMis++; $display("FAIL clr_empty got %b want 1", fifo_empty);
    end
    nVec++;
    if (done !== 1'b0) begin
      nMis++; $display("FAIL clr_done got %b want 0", done);
    end
    nVec++;
    if (move_count !== 9'd0) begin
      nMis++; $display("FAIL clr_count got %0d want 0", move_count);
    end
    nVec++;
    if (fifo_out !== termW) begin
      nMis++; $display("FAIL clr_out got %h want %h", fifo_out, termW);
    end
    step(0, '0, 1, 0);
    runToDone();
    step(0, '0, 0, 1);
    nVec++;
    if (fifo_out !== termW) begin
      nMis++; $display("FAIL clr_discard got %h want %h", fifo_out, termW);
    end
  endtask

  task automatic test_saturation();
    doClear();
    for (int i = 0; i < 520; i++) begin
      step(1, 18'($urandom), 0, 1);
      nVec++;
      if (fifo_out !== mOut) begin
        nMis++; $display("FAIL sat_out@%0d got %h want %h", i, fifo_out, mOut);
      end
    end
    nVec++;
    if (move_count !== 9'd511) begin
      nMis++; $display("FAIL sat_count got %0d want 511", move_count);
    end
  endtask

  task automatic test_random(input int rdPct, input int gdPct);
    bit mv, gd, rd;
    doClear();
    for (int i = 0; i < 500; i++) begin
      mv = $urandom_range(0, 99) < 75;
      gd = $urandom_range(0, 999) < gdPct;
      rd = $urandom_range(0, 99) < rdPct;
      step(mv, 18'($urandom), gd, rd);
      nVec++;
      if (fifo_out !== mOut) begin
        nMis++; $display("FAIL rnd_out@%0d got %h want %h", i, fifo_out, mOut);
      end
      nVec++;
      if (done !== (mPhase == 3)) begin
        nMis++; $display("FAIL rnd_done@%0d got %b want %b", i, done, mPhase == 3);
      end
      nVec++;
      if (fifo_empty !== (mFifo.size() == 0)) begin
        nMis++; $display("FAIL rnd_empty@%0d got %b want %b", i, fifo_empty, mFifo.size() == 0);
      end
      nVec++;
      if (move_count !== 9'(mCount)) begin
        nMis++; $display("FAIL rnd_count@%0d got %0d want %0d", i, move_count, mCount);
      end
      nVec++;
      if (move_ready !== mReady()) begin
        nMis++; $display("FAIL rnd_ready@%0d got %b want %b", i, move_ready, mReady());
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(0, '0, 0, 1);
      nVec++;
      if (fifo_out !== mOut) begin
        nMis++; $display("FAIL rnd_drain@%0d got %h want %h", i, fifo_out, mOut);
      end
    end
  endtask

  initial begin
    termW = buildWord('{});
    reset = 1;
    clear = 0;
    move_valid = 0;
    move_in = '0;
    gen_done = 0;
    rden = 0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    test_reset();
    test_empty_read();
    test_three_moves();
    test_eight(0);
    test_eight(1);
    test_stall();
    test_clear_mid();
    test_saturation();
    test_random(40, 8);
    test_random(5, 3);
    test_random(90, 20);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
